pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Program-counter register and instruction-fetch sequencer.
- Sits at the consuming end of the next-address path: holds the current PC and drives it to the next-address logic. It samples the returned next-PC, fetches the word from instruction memory over a req/ack handshake, and presents the instruction to decode with valid/stall.
- PC is word-addressed: consecutive instructions differ by 1.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- ADDR_W, 8, instruction-memory address width; imem_addr = pc[ADDR_W-1:0].
- TIMEOUT, 16, cycles without ack before fetch error (only with IMEM_TIMEOUT_EN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- next_pc  input  32  next instruction address from the next-address logic.
- pc  output  32  current PC, fed back to the next-address logic.
- imem_req  output  1  fetch request, held until ack.
- imem_addr  output  ADDR_W  fetch address.
- imem_ack  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  instruction to decode; instr[25:0] is the jump field.
- instr_valid  output  1  instr holds a fetched, unconsumed instruction.
- stall  input  1  decode cannot accept instr this cycle.
- fetch_err  output  1  sticky timeout flag (tied 0 when feature is off).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, state=IDLE.
  - Asserting reset mid-request drops imem_req immediately; any ack arriving during reset is ignored.
- FSM states: IDLE, REQ, VALID.
  - IDLE: entered only from reset. First clock after rst_n deasserts -> REQ.
  - REQ:
    - imem_req=1 and imem_addr=pc[ADDR_W-1:0], both combinational from state and pc; stable until ack.
    - On an imem_ack cycle: instr<=imem_rdata, instr_valid<=1, -> VALID.
    - Ack in the first REQ cycle is legal, giving 1-cycle memory latency.
  - VALID:
    - instr_valid=1, imem_req=0.
    - stall=1: pc, instr and instr_valid hold.
    - stall=0: instruction consumed this edge. pc<=next_pc, instr_valid<=0, -> REQ.
    - instr keeps its old value until the next ack.
- Throughput: minimum 2 cycles per instruction (REQ+ack, VALID). Fetch-to-valid latency is 1 cycle after the ack edge.
- next_pc is sampled only on the VALID & !stall edge. It may change freely at any other time.
- pc changes only on that edge or on reset. It is stable while the next-address logic computes from it.
- Width/wrap:
  - pc is the full 32 bits of next_pc with no arithmetic in this block.
  - imem_addr truncates to the low ADDR_W bits, so pc=32'h0000_0100 with ADDR_W=8 fetches address 0.
- imem_ack outside REQ is ignored. No state change; instr is not overwritten.
- stall outside VALID has no effect.
- An ack that coincides with stall=1 is captured; stall only matters in VALID.

Optional Feature:
- Macro: IMEM_TIMEOUT_EN.
- Defined:
  - A wait counter resets to 0 on entering REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT-1 without ack, fetch_err<=1 (sticky until reset), counter<=0, and the request is retried at the same pc; imem_req stays high.
  - Counter width is clog2(TIMEOUT)+1.
- Undefined: no counter logic; fetch_err is constant 0 and REQ waits indefinitely.

Decomposition:
- Shared package (mips_pkg):
  - fetch state encoding constants FS_IDLE=2'd0, FS_REQ=2'd1, FS_VALID=2'd2.
  - Default RESET_PC.
  - Instruction field offsets, including JUMP_FIELD_W=26.
- Optional sub-module fetch_timer, instantiated only under IMEM_TIMEOUT_EN.
  - Inputs: clk, rst_n, enable (state==REQ & !imem_ack), clear (entering REQ).
  - Output: expire pulse.

Test Plan:
- Reset release, ack on first REQ cycle with rdata=32'h2001_0005 -> imem_addr=0 during REQ; next cycle instr=32'h2001_0005, instr_valid=1, pc=0.
- Sequential run, next_pc=pc+1, 1-cycle ack, stall=0 -> pc steps 0,1,2,3 every 2 cycles; imem_req alternates 1,0.
- stall=1 for 3 cycles in VALID with next_pc changing -> pc, instr and instr_valid constant. On release, pc takes the next_pc present on the release edge.
- Jump redirect: next_pc=32'h0000_0040 on consume -> following REQ has imem_addr=8'h40. Then next_pc=32'h0000_0105 -> imem_addr=8'h05, pc=32'h0000_0105.
- Memory delays ack 5 cycles; a spurious ack is injected in VALID -> imem_addr held for all 5 cycles; spurious ack leaves instr unchanged.
- IMEM_TIMEOUT_EN, TIMEOUT=4, no ack for 4 cycles -> fetch_err=1 on the 4th edge, imem_req still 1; a later ack completes normally and fetch_err stays 1. rst_n pulse mid-REQ -> imem_req=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg -- definitions shared by the fetch-stage files.
//   * Fetch FSM state encoding (plain 2-bit constants so older tools and
//     existing netlists that probe the state register keep working).
//   * Default reset program counter.
//   * Instruction field offsets/widths used by the fetch and decode stages.
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FS_IDLE  = 2'd0;
  localparam fetch_state_t FS_REQ   = 2'd1;
  localparam fetch_state_t FS_VALID = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

  // Instruction field layout (bit offset of the field LSB and field width).
  localparam int OPCODE_LSB   = 26;
  localparam int OPCODE_W     = 6;
  localparam int RS_LSB       = 21;
  localparam int RT_LSB       = 16;
  localparam int RD_LSB       = 11;
  localparam int REG_W        = 5;
  localparam int IMM_W        = 16;
  localparam int JUMP_FIELD_W = 26;

endpackage

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer -- instruction-memory wait counter.
//   Only built when IMEM_TIMEOUT_EN is defined; without that macro this file
//   contributes no module.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   enable  in   a request cycle that did not receive an ack
//   clear   in   the fetch FSM is entering the request state
//   expire  out  single-cycle pulse: TIMEOUT ack-less request cycles elapsed
// -----------------------------------------------------------------------------
`ifdef IMEM_TIMEOUT_EN
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Expire on the ack-less cycle whose count is TIMEOUT-1, so the flag lands
  // on the TIMEOUT-th edge of an unanswered request.
  assign expire = enable && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear || expire) begin
      // Expiry restarts the count so the retried request gets a full window.
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch -- program-counter register and instruction-fetch sequencer.
//   Holds the word-addressed PC, fetches the instruction at that PC over a
//   req/ack handshake and hands it to decode with valid/stall. A new PC is
//   taken from next_pc only when decode consumes the current instruction.
//
// Optional feature: define IMEM_TIMEOUT_EN to add a fetch timeout. After
//   TIMEOUT request cycles without ack, fetch_err is set (sticky until reset)
//   and the request continues at the same PC. Without the macro fetch_err is
//   constant 0 and a request waits indefinitely.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   next_pc      in   [31:0] next instruction address
//   pc           out  [31:0] current PC, fed back to next-address logic
//   imem_req     out  fetch request, held until ack
//   imem_addr    out  [ADDR_W-1:0] fetch address (low bits of pc)
//   imem_ack     in   imem_rdata is valid this cycle
//   imem_rdata   in   [31:0] fetched instruction word
//   instr        out  [31:0] instruction to decode
//   instr_valid  out  instr holds a fetched, unconsumed instruction
//   stall        in   decode cannot accept instr this cycle
//   fetch_err    out  sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 8
`ifdef IMEM_TIMEOUT_EN
  ,
  parameter int          TIMEOUT  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       next_pc,
  output logic [31:0]       pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              stall,
  output logic              fetch_err
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic         valid_reg;

  // Request and address come straight from state and pc so they drop in the
  // same instant as an asynchronous reset and never glitch during a request.
  assign imem_req    = (state_reg == FS_REQ);
  assign imem_addr   = pc_reg[ADDR_W-1:0];
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FS_IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FS_IDLE: begin
          state_reg <= FS_REQ;
        end
        FS_REQ: begin
          // stall is deliberately ignored here: an ack is always captured.
          if (imem_ack) begin
            instr_reg <= imem_rdata;
            valid_reg <= 1'b1;
            state_reg <= FS_VALID;
          end
        end
        FS_VALID: begin
          // Acks arriving here are stray and must not touch instr.
          if (!stall) begin
            pc_reg    <= next_pc;
            valid_reg <= 1'b0;
            state_reg <= FS_REQ;
          end
        end
        default: begin
          state_reg <= FS_IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_TIMEOUT_EN
  logic enter_req;
  logic timer_expire;
  logic err_reg;

  assign enter_req = (state_reg == FS_IDLE) ||
                     ((state_reg == FS_VALID) && !stall);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable ((state_reg == FS_REQ) && !imem_ack),
    .clear  (enter_req),
    .expire (timer_expire)
  );

  // The retry needs no extra state: the FSM simply stays in REQ at the same pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (timer_expire) begin
      err_reg <= 1'b1;
    end
  end

  assign fetch_err = err_reg;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch -- self-checking bench for pc_fetch.
//   Inputs change and outputs are sampled on the falling clock edge. Each
//   acknowledged fetch pushes its expected {instr, pc} onto a scoreboard that
//   is popped and compared when instr_valid is observed.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

`ifdef IMEM_TIMEOUT_EN
  pc_fetch #(.RESET_PC(32'd0), .ADDR_W(8), .TIMEOUT(4)) dut (
`else
  pc_fetch #(.RESET_PC(32'd0), .ADDR_W(8)) dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .fetch_err   (fetch_err)
  );

  // Reset pulse; returns on the falling edge of the first REQ cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; next_pc = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Acknowledge for one cycle and record what decode should then see.
  task automatic ack_now(input logic [31:0] data, input logic [31:0] exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb.push_back('{instr: data, pc: exp_pc});
    @(negedge clk);
    imem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; next_pc = '0; imem_rdata = '0;
    @(negedge clk);
    checks++;
    if ({pc, instr, instr_valid, imem_req, fetch_err} !== {32'd0, 32'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b err=%b required 0", pc, instr, instr_valid, imem_req, fetch_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h required 1/00", imem_req, imem_addr);
    end
    ack_now(32'h2001_0005, 32'd0);
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL first_valid: valid=%b req=%b required 1/0", instr_valid, imem_req);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL first_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (instr !== e.instr || pc !== e.pc) begin
        failures++;
        $display("FAIL first_instr: instr=%h pc=%h required %h/%h", instr, pc, e.instr, e.pc);
      end
    end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    exp_pc = 32'd0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc[7:0] || pc !== exp_pc || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_req[%0d]: req=%b addr=%h pc=%h valid=%b required 1/%h/%h/0", i, imem_req, imem_addr, pc, instr_valid, exp_pc[7:0], exp_pc);
      end
      ack_now(32'hA000_0000 + 32'(i), exp_pc);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq_valid[%0d]: req=%b valid=%b required 0/1", i, imem_req, instr_valid);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL seq_sb[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (instr !== e.instr || pc !== e.pc) begin
          failures++;
          $display("FAIL seq_instr[%0d]: instr=%h pc=%h required %h/%h", i, instr, pc, e.instr, e.pc);
        end
      end
      next_pc = exp_pc + 32'd1;
      exp_pc  = exp_pc + 32'd1;
      @(negedge clk);
    end
    $display("test_sequential done pc=%h checks=%0d", pc, checks);
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1;                     // ack with stall high is still captured
    ack_now(32'h1234_5678, 32'd0);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL stall_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
        failures++;
        $display("FAIL stall_capture: valid=%b instr=%h pc=%h required 1/%h/%h", instr_valid, instr, pc, e.instr, e.pc);
      end
    end
    for (int k = 0; k < 3; k++) begin
      next_pc = $urandom;
      @(negedge clk);
      checks++;
      if (pc !== 32'd0 || instr !== 32'h1234_5678 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h valid=%b req=%b required 0/12345678/1/0", k, pc, instr, instr_valid, imem_req);
      end
    end
    stall   = 1'b0;
    next_pc = 32'h0000_0077;
    @(negedge clk);
    checks++;
    if (pc !== 32'h77 || instr_valid !== 1'b0 || imem_req !== 1'b1 || instr !== 32'h1234_5678) begin
      failures++;
      $display("FAIL stall_release: pc=%h valid=%b req=%b instr=%h required 77/0/1/12345678", pc, instr_valid, imem_req, instr);
    end
    stall = 1'b1;                     // stall in REQ without ack: no effect
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || pc !== 32'h77 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_in_req: req=%b pc=%h valid=%b required 1/77/0", imem_req, pc, instr_valid);
    end
    stall = 1'b0;
    $display("test_stall done checks=%0d", checks);
  endtask

  task automatic test_jump();
    logic [31:0] targets [3];
    logic [7:0]  addrs   [3];
    targets = '{32'h0000_0040, 32'h0000_0105, 32'h0000_0100};
    addrs   = '{8'h40, 8'h05, 8'h00};
    do_reset();
    ack_now(32'h0800_0010, 32'd0);
    void'(sb.pop_front());
    for (int j = 0; j < 3; j++) begin
      next_pc = targets[j];
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addrs[j] || pc !== targets[j]) begin
        failures++;
        $display("FAIL jump[%0d]: req=%b addr=%h pc=%h required 1/%h/%h", j, imem_req, imem_addr, pc, addrs[j], targets[j]);
      end
      ack_now(32'h0C00_0000 | targets[j], targets[j]);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL jump_sb[%0d]: scoreboard empty", j);
      end else begin
        e = sb.pop_front();
        if (instr !== e.instr || pc !== e.pc || instr_valid !== 1'b1) begin
          failures++;
          $display("FAIL jump_instr[%0d]: instr=%h pc=%h valid=%b required %h/%h/1", j, instr, pc, instr_valid, e.instr, e.pc);
        end
      end
    end
    $display("test_jump done checks=%0d", checks);
  endtask

  task automatic test_delayed_ack();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL delay_wait[%0d]: req=%b addr=%h valid=%b required 1/00/0", k, imem_req, imem_addr, instr_valid);
      end
      next_pc = $urandom;              // ignored outside a consume edge
      @(negedge clk);
    end
    ack_now(32'h2002_0009, 32'd0);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL delay_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (instr !== e.instr || pc !== e.pc || instr_valid !== 1'b1) begin
        failures++;
        $display("FAIL delay_instr: instr=%h pc=%h valid=%b required %h/%h/1", instr, pc, instr_valid, e.instr, e.pc);
      end
    end
    stall      = 1'b1;                 // stray ack while VALID
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    checks++;
    if (instr !== 32'h2002_0009 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL spurious_ack: instr=%h valid=%b req=%b required 20020009/1/0", instr, instr_valid, imem_req);
    end
    stall   = 1'b0;
    next_pc = 32'd5;
    @(negedge clk);
    checks++;
    if (pc !== 32'd5 || imem_req !== 1'b1 || instr !== 32'h2002_0009) begin
      failures++;
      $display("FAIL delay_resume: pc=%h req=%b instr=%h required 5/1/20020009", pc, imem_req, instr);
    end
    $display("test_delayed_ack done checks=%0d", checks);
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    ack_now(32'h1111_2222, 32'd0);
    void'(sb.pop_front());
    next_pc = 32'h21;
    @(negedge clk);
    rst_n      = 1'b0;                 // async reset while requesting
    imem_ack   = 1'b1;
    imem_rdata = 32'h3333_4444;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'd0 || instr !== 32'd0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_req: req=%b pc=%h instr=%h err=%b required 0/0/0/0", imem_req, pc, instr, fetch_err);
    end
    @(negedge clk);
    checks++;
    if (instr !== 32'd0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_in_reset: instr=%h valid=%b required 0/0", instr, instr_valid);
    end
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    $display("test_reset_mid_req done checks=%0d", checks);
  endtask

`ifdef IMEM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (fetch_err !== (k == 4) || imem_req !== 1'b1) begin
        failures++;
        $display("FAIL timeout[%0d]: err=%b req=%b required %b/1", k, fetch_err, imem_req, (k == 4));
      end
    end
    ack_now(32'h4444_0001, 32'd0);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL timeout_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (instr !== e.instr || instr_valid !== 1'b1 || fetch_err !== 1'b1) begin
        failures++;
        $display("FAIL timeout_done: instr=%h valid=%b err=%b required %h/1/1", instr, instr_valid, fetch_err, e.instr);
      end
    end
    $display("test_timeout done checks=%0d", checks);
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    repeat (20) @(negedge clk);
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL no_timeout: err=%b req=%b required 0/1", fetch_err, imem_req);
    end
    $display("test_no_timeout done checks=%0d", checks);
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_delayed_ack();
    test_reset_mid_req();
`ifdef IMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
